// File: rtl/pm_loader.sv
// Program-memory loader and run sequencer for the MIPS2 core: streams words into PM, releases
// core reset, times the run. Define PM_LOADER_CHECKSUM_EN to add a running sum of written words.
module pm_loader #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     I_START,
    input  logic [$clog2(DEPTH)-1:0] I_BASE_IDX,
    input  logic [$clog2(DEPTH):0]   I_LEN,
    input  logic                     I_ABORT,
    input  logic                     I_VALID,
    input  logic [DATA_W-1:0]        I_DATA,
    output logic                     O_READY,
    output logic                     O_PM_WR,
    output logic [DATA_W-1:0]        O_PM_WR_DATA,
    output logic [ADDR_W-1:0]        O_PM_WR_ADDR,
    output logic                     O_CORE_RESET,
    input  logic                     I_FINISHED,
    output logic                     O_BUSY,
    output logic                     O_DONE,
    output logic                     O_TIMEOUT,
    output logic                     O_ERR,
    output logic [CYC_W-1:0]         O_CYCLES,
    output logic [DATA_W-1:0]        O_CHECKSUM
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W+1:0] DepthW = (IDX_W + 2)'(DEPTH);
    // Wraps to all-ones when MAX_CYCLES is 0; the compare is gated off in that case.
    localparam logic [CYC_W-1:0] CycLast = CYC_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRelease,
        StRun,
        StDone,
        StTimeout,
        StErr
    } state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W:0]      r_remaining;
    logic                r_wr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [CYC_W-1:0]    r_cycles;

    logic                w_can_start;
    logic                w_start;
    logic                w_range_err;
    logic [IDX_W+1:0]    w_end;
    logic                w_ready;
    logic                w_accept;
    logic                w_timeout;
    logic                w_count;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_next = r_state;
        w_can_start  = 1'b0;
        w_start      = 1'b0;
        w_end        = {2'b00, I_BASE_IDX} + {1'b0, I_LEN};
        w_range_err  = 1'b0;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        w_count      = 1'b0;

        O_READY      = 1'b0;
        O_PM_WR      = r_wr;
        O_PM_WR_DATA = r_wr_data;
        O_PM_WR_ADDR = r_wr_addr;
        O_CORE_RESET = 1'b1;
        O_BUSY       = 1'b0;
        O_DONE       = 1'b0;
        O_TIMEOUT    = 1'b0;
        O_ERR        = 1'b0;
        O_CYCLES     = r_cycles;

        w_can_start = (r_state == StIdle) || (r_state == StDone) ||
                      (r_state == StTimeout) || (r_state == StErr);
        w_start     = I_START && w_can_start && !I_ABORT;
        w_range_err = w_end > DepthW;
        w_ready     = (r_state == StLoad) && (r_remaining != '0);
        w_accept    = w_ready && I_VALID && !I_ABORT;
        w_timeout   = (MAX_CYCLES != 0) && (r_cycles == CycLast);
        w_count     = (r_state == StRun) && !I_FINISHED && !w_timeout && (r_cycles != '1);

        if (I_ABORT) begin
            w_state_next = StIdle;
        end else if (w_start) begin
            if (w_range_err) begin
                w_state_next = StErr;
            end else if (I_LEN == '0) begin
                w_state_next = StRelease;
            end else begin
                w_state_next = StLoad;
            end
        end else begin
            case (r_state)
                // remaining hits 0 in the cycle the last write is presented
                StLoad:    if (r_remaining == '0) w_state_next = StRelease;
                StRelease: w_state_next = StRun;
                StRun: begin
                    if (I_FINISHED) begin
                        w_state_next = StDone;
                    end else if (w_timeout) begin
                        w_state_next = StTimeout;
                    end
                end
                default:   w_state_next = r_state;
            endcase
        end

        O_READY      = w_ready;
        O_CORE_RESET = !((r_state == StRun) || (r_state == StDone));
        O_BUSY       = (r_state == StLoad) || (r_state == StRun);
        O_DONE       = (r_state == StDone);
        O_TIMEOUT    = (r_state == StTimeout);
        O_ERR        = (r_state == StErr);
    end

    // Load pointer, one-deep write stage and run counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idx       <= '0;
            r_remaining <= '0;
            r_wr        <= 1'b0;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
            r_cycles    <= '0;
        end else begin
            r_wr <= w_accept;
            if (w_accept) begin
                r_wr_data   <= I_DATA;
                r_wr_addr   <= ADDR_W'(r_idx) * ADDR_W'(ADDR_STEP);
                r_idx       <= r_idx + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            if (I_ABORT) begin
                r_remaining <= '0;
                r_cycles    <= '0;
            end else if (w_start) begin
                r_idx       <= I_BASE_IDX;
                r_remaining <= w_range_err ? '0 : I_LEN;
                r_cycles    <= '0;
            end else if (w_count) begin
                r_cycles <= r_cycles + 1'b1;
            end
        end
    end

`ifdef PM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_csum <= '0;
        end else if (I_ABORT || w_start) begin
            r_csum <= '0;
        end else if (r_wr) begin
            r_csum <= r_csum + r_wr_data;
        end
    end

    assign O_CHECKSUM = r_csum;
`else
    assign O_CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader: table-driven loads/runs, abort and reset corner cases,
// and randomized loads checked against a rule-level model.
module tb_pm_loader;

    localparam int DEPTH = 32;
    localparam int STEP  = 4;
    localparam int MAXC  = 16;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        I_START;
    logic [4:0]  I_BASE_IDX;
    logic [5:0]  I_LEN;
    logic        I_ABORT;
    logic        I_VALID;
    logic [31:0] I_DATA;
    logic        O_READY;
    logic        O_PM_WR;
    logic [31:0] O_PM_WR_DATA;
    logic [31:0] O_PM_WR_ADDR;
    logic        O_CORE_RESET;
    logic        I_FINISHED;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_TIMEOUT;
    logic        O_ERR;
    logic [31:0] O_CYCLES;
    logic [31:0] O_CHECKSUM;

    pm_loader #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .DEPTH      (DEPTH),
        .ADDR_STEP  (STEP),
        .CYC_W      (32),
        .MAX_CYCLES (MAXC)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .I_START      (I_START),
        .I_BASE_IDX   (I_BASE_IDX),
        .I_LEN        (I_LEN),
        .I_ABORT      (I_ABORT),
        .I_VALID      (I_VALID),
        .I_DATA       (I_DATA),
        .O_READY      (O_READY),
        .O_PM_WR      (O_PM_WR),
        .O_PM_WR_DATA (O_PM_WR_DATA),
        .O_PM_WR_ADDR (O_PM_WR_ADDR),
        .O_CORE_RESET (O_CORE_RESET),
        .I_FINISHED   (I_FINISHED),
        .O_BUSY       (O_BUSY),
        .O_DONE       (O_DONE),
        .O_TIMEOUT    (O_TIMEOUT),
        .O_ERR        (O_ERR),
        .O_CYCLES     (O_CYCLES),
        .O_CHECKSUM   (O_CHECKSUM)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] words[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (O_PM_WR) begin
            wr_addr_q.push_back(O_PM_WR_ADDR);
            wr_data_q.push_back(O_PM_WR_DATA);
            wr_cyc_q.push_back(cyc);
        end
    end

    typedef struct {
        int base;
        int len;
        int gap;
        int fin_at;
        bit plan;
        bit exp_err;
        bit exp_done;
        bit exp_to;
        int exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, O_CORE_RESET, 1);
        check({tag, "_ready"}, O_READY, 0);
        check({tag, "_pm_wr"}, O_PM_WR, 0);
        check({tag, "_wr_addr"}, O_PM_WR_ADDR, 0);
        check({tag, "_wr_data"}, O_PM_WR_DATA, 0);
        check({tag, "_busy"}, O_BUSY, 0);
        check({tag, "_done"}, O_DONE, 0);
        check({tag, "_timeout"}, O_TIMEOUT, 0);
        check({tag, "_err"}, O_ERR, 0);
        check({tag, "_cycles"}, O_CYCLES, 0);
        check({tag, "_csum"}, O_CHECKSUM, 0);
    endtask

    // Outcome of a START/run purely from the stated rules
    function automatic void model_run(input int base, input int len, input int fin_at,
                                      output bit err, output bit done, output bit to,
                                      output int cycles);
        err    = (base + len) > DEPTH;
        done   = !err && (fin_at >= 1) && (fin_at <= MAXC);
        to     = !err && !done;
        cycles = err ? 0 : (done ? fin_at - 1 : MAXC - 1);
    endfunction

    task automatic run_case(input int base, input int len, input int gap, input int fin_at,
                            input bit exp_err, input bit exp_done, input bit exp_to,
                            input int exp_cyc);
        int          cs;
        int          t;
        int          kmax;
        int          run_len;
        int          exp_first;
        bit          cyc_ok;
        logic [31:0] sum;
        logic [31:0] exp_csum;
        int          acc[$];

        clear_writes();
        sum = 32'h0;
        for (int i = 0; i < words.size(); i++) sum = sum + words[i];
`ifdef PM_LOADER_CHECKSUM_EN
        exp_csum = sum;
`else
        exp_csum = 32'h0;
`endif
        I_START    = 1'b1;
        I_BASE_IDX = 5'(base);
        I_LEN      = 6'(len);
        cs         = cyc;
        step();
        I_START = 1'b0;

        if (exp_err) begin
            check("err_flag", O_ERR, 1);
            check("err_core_reset", O_CORE_RESET, 1);
            check("err_busy", O_BUSY, 0);
            I_VALID = 1'b1;
            repeat (3) step();
            I_VALID = 1'b0;
            check("err_writes", wr_addr_q.size(), 0);
            check("err_flag_hold", O_ERR, 1);
            check("err_csum", O_CHECKSUM, 0);
            return;
        end

        for (int i = 0; i < len; i++) begin
            I_VALID = 1'b1;
            I_DATA  = words[i];
            t = 0;
            while (!O_READY && t < 20) begin
                step();
                t++;
            end
            if (t >= 20) begin
                check("ready_wait", 0, 1);
                break;
            end
            acc.push_back(cyc);
            step();
            if (gap > 0 && i < len - 1) begin
                I_VALID = 1'b0;
                I_DATA  = $urandom;
                repeat (gap) step();
            end
        end
        // Valid stays high past the last beat; none of it may be written
        I_VALID = 1'b1;
        I_DATA  = 32'hDEAD_BEEF;
        t = 0;
        while (O_CORE_RESET && t < 10) begin
            step();
            t++;
        end
        I_VALID = 1'b0;
        exp_first = (acc.size() > 0) ? acc[acc.size()-1] + 3 : cs + 2;
        check("release_timing", cyc, exp_first);
        check("run_busy", O_BUSY, 1);

        run_len = exp_done ? fin_at : MAXC;
        kmax    = (fin_at > 0) ? fin_at : MAXC + 4;
        cyc_ok  = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            if (k <= run_len && O_CYCLES != 32'(k - 1)) cyc_ok = 1'b0;
            if (k == fin_at) I_FINISHED = 1'b1;
            if (k == 3) begin
                I_START    = 1'b1;
                I_BASE_IDX = 5'd30;
                I_LEN      = 6'd3;
            end
            step();
            I_FINISHED = 1'b0;
            I_START    = 1'b0;
        end
        repeat (2) step();

        check("run_count", cyc_ok, 1);
        check("final_done", O_DONE, exp_done);
        check("final_timeout", O_TIMEOUT, exp_to);
        check("final_cycles", O_CYCLES, exp_cyc);
        check("final_core_reset", O_CORE_RESET, !exp_done);
        check("final_busy", O_BUSY, 0);
        check("final_err", O_ERR, 0);
        check("final_csum", O_CHECKSUM, exp_csum);
        check("wr_count", wr_addr_q.size(), len);
        for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
            check("wr_addr", wr_addr_q[i], 32'((base + i) * STEP));
            check("wr_data", wr_data_q[i], words[i]);
            if (i < acc.size()) check("wr_latency", wr_cyc_q[i], acc[i] + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        bit d;
        bit to;
        int c;
        int base;
        int len;
        int gap;
        int fin;
        logic [31:0] plan_words[3];

        plan_words[0] = 32'h2008_0005;
        plan_words[1] = 32'h2009_0007;
        plan_words[2] = 32'h0109_5020;

        RESET_N    = 1'b0;
        I_START    = 1'b0;
        I_BASE_IDX = '0;
        I_LEN      = '0;
        I_ABORT    = 1'b0;
        I_VALID    = 1'b0;
        I_DATA     = '0;
        I_FINISHED = 1'b0;

        #7;
        check_reset_vals("reset");
        #6;
        RESET_N = 1'b1;
        step();

        //            base len gap fin plan err done to cyc
        vecs[0] = '{30, 3, 0, 0,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{0,  0, 0, 16, 1'b0, 1'b0, 1'b1, 1'b0, 15};
        vecs[2] = '{5,  2, 3, 0,  1'b0, 1'b0, 1'b0, 1'b1, 15};
        vecs[3] = '{31, 1, 1, 17, 1'b0, 1'b0, 1'b0, 1'b1, 15};
        vecs[4] = '{2,  4, 0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[5] = '{0,  3, 0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 9};

        foreach (vecs[n]) begin
            words.delete();
            for (int j = 0; j < vecs[n].len; j++)
                words.push_back(vecs[n].plan ? plan_words[j] : $urandom);
            run_case(vecs[n].base, vecs[n].len, vecs[n].gap, vecs[n].fin_at,
                     vecs[n].exp_err, vecs[n].exp_done, vecs[n].exp_to, vecs[n].exp_cyc);
        end

        // Abort from DONE clears flags and counter
        I_ABORT = 1'b1;
        step();
        I_ABORT = 1'b0;
        check("abort_done_clr", O_DONE, 0);
        check("abort_cycles_clr", O_CYCLES, 0);
        check("abort_core_reset", O_CORE_RESET, 1);

        // Abort after one of four beats; the beat offered with ABORT is dropped
        clear_writes();
        I_START    = 1'b1;
        I_BASE_IDX = 5'd0;
        I_LEN      = 6'd4;
        step();
        I_START = 1'b0;
        check("load_ready", O_READY, 1);
        I_VALID = 1'b1;
        I_DATA  = 32'h1111_1111;
        step();
        I_DATA  = 32'h2222_2222;
        I_ABORT = 1'b1;
        step();
        I_ABORT = 1'b0;
        check("abort_ready", O_READY, 0);
        check("abort_busy", O_BUSY, 0);
        check("abort_pm_wr", O_PM_WR, 0);
        repeat (3) step();
        I_VALID = 1'b0;
        check("abort_writes", wr_addr_q.size(), 1);

        // ABORT beats START in the same cycle
        I_START = 1'b1;
        I_ABORT = 1'b1;
        I_LEN   = 6'd2;
        step();
        I_START = 1'b0;
        I_ABORT = 1'b0;
        check("abort_vs_start_ready", O_READY, 0);
        check("abort_vs_start_busy", O_BUSY, 0);

        // Asynchronous reset mid-load with a write on the bus
        clear_writes();
        I_START = 1'b1;
        I_LEN   = 6'd4;
        step();
        I_START = 1'b0;
        I_VALID = 1'b1;
        I_DATA  = 32'hAAAA_0001;
        step();
        I_DATA  = 32'hAAAA_0002;
        step();
        I_VALID = 1'b0;
        check("pre_reset_pm_wr", O_PM_WR, 1);
        #1;
        RESET_N = 1'b0;
        #1;
        check_reset_vals("midload_reset");
        #1;
        RESET_N = 1'b1;
        step();
        check("post_reset_writes", wr_addr_q.size(), 1);
        check("post_reset_ready", O_READY, 0);

        // Randomized loads against the model
        for (int n = 0; n < 10; n++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 6);
            gap  = $urandom_range(0, 2);
            fin  = $urandom_range(0, 19);
            words.delete();
            for (int j = 0; j < len; j++) words.push_back($urandom);
            model_run(base, len, fin, e, d, to, c);
            run_case(base, len, gap, fin, e, d, to, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
